instr_loader: RTL

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 26 ++
 rtl/instr_word_assembler.sv | 35 +++
 rtl/instr_loader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared states, address defaults and word limit for the instruction loader
package instr_loader_pkg;

  // Loader session states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } loader_state_t;

  // Width of the word-count input and remaining-word counter
  localparam int COUNT_W = 11;

  // Default instruction-memory window
  localparam logic [31:0] DEFAULT_INITIAL_ADDR = 32'h0000_8000;
  localparam logic [31:0] DEFAULT_LAST_ADDR    = 32'h0000_8FFF;

  // Number of whole 32-bit words that fit in [first, last]
  function automatic logic [31:0] word_limit(input logic [31:0] first, input logic [31:0] last);
    return (last - first + 32'd1) >> 2;
  endfunction

  localparam logic [31:0] DEFAULT_WORD_LIMIT = word_limit(DEFAULT_INITIAL_ADDR, DEFAULT_LAST_ADDR);

endpackage

// File: rtl/instr_word_assembler.sv
// rtl/instr_word_assembler.sv - packs four little-endian bytes into one 32-bit instruction word
module instr_word_assembler (
  input  logic        ip_clk,
  input  logic        ip_rst,
  input  logic        ip_clear,
  input  logic        ip_accept,
  input  logic [7:0]  ip_byte_data,
  output logic [31:0] op_word,
  output logic        op_word_complete
);

  logic [1:0]  byte_idx;
  logic [23:0] low_bytes;

  // The top byte is never stored: it is merged combinationally when the word completes
  assign op_word          = {ip_byte_data, low_bytes};
  assign op_word_complete = ip_accept && (byte_idx == 2'd3);

  // Store bytes 0..2 in place and advance the index; a reset or clear drops any partial word
  always_ff @(posedge ip_clk) begin
    if (ip_rst || ip_clear) begin
      byte_idx  <= 2'd0;
      low_bytes <= 24'd0;
    end else if (ip_accept) begin
      case (byte_idx)
        2'd0:    low_bytes[7:0]   <= ip_byte_data;
        2'd1:    low_bytes[15:8]  <= ip_byte_data;
        2'd2:    low_bytes[23:16] <= ip_byte_data;
        default: low_bytes        <= low_bytes;
      endcase
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - loads a byte stream into instruction memory while holding the core
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter logic [31:0] initial_addr = DEFAULT_INITIAL_ADDR,
  parameter logic [31:0] last_addr    = DEFAULT_LAST_ADDR
) (
  input  logic               ip_clk,
  input  logic               ip_rst,
  input  logic               ip_load_start,
  input  logic [COUNT_W-1:0] ip_word_count,
  input  logic               ip_byte_valid,
  input  logic [7:0]         ip_byte_data,
  output logic               op_byte_ready,
  output logic               op_wr_en,
  output logic [31:0]        op_wr_addr,
  output logic [31:0]        op_wr_data,
  output logic               op_core_hold,
  output logic               op_busy,
  output logic               op_done,
  output logic               op_error,
  output logic [31:0]        op_checksum
);

  localparam logic [31:0] WORD_LIMIT = word_limit(initial_addr, last_addr);

  loader_state_t      state;
  logic [COUNT_W-1:0] remaining;
  logic               count_in_range;
  logic               start_ok;
  logic               start_bad;
  logic               byte_accept;
  logic               word_complete;
  logic [31:0]        assembled_word;

  // Ready is only ever high in COLLECT, so this also confines acceptance to COLLECT
  assign byte_accept    = op_byte_ready && ip_byte_valid;
  assign count_in_range = (ip_word_count != '0) && ({21'd0, ip_word_count} <= WORD_LIMIT);
  assign start_ok       = (state == ST_IDLE) && ip_load_start && count_in_range;
  assign start_bad      = (state == ST_IDLE) && ip_load_start && !count_in_range;

  instr_word_assembler u_assembler (
    .ip_clk           (ip_clk),
    .ip_rst           (ip_rst),
    .ip_clear         (start_ok),
    .ip_accept        (byte_accept),
    .ip_byte_data     (ip_byte_data),
    .op_word          (assembled_word),
    .op_word_complete (word_complete)
  );

  // Session FSM; every output is registered so the write port stays stable for its whole cycle
  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      state         <= ST_IDLE;
      remaining     <= '0;
      op_byte_ready <= 1'b0;
      op_wr_en      <= 1'b0;
      op_wr_addr    <= initial_addr;
      op_wr_data    <= 32'd0;
      op_core_hold  <= 1'b0;
      op_busy       <= 1'b0;
      op_done       <= 1'b0;
      op_error      <= 1'b0;
      op_checksum   <= 32'd0;
    end else begin
      op_done  <= 1'b0;
      op_wr_en <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state         <= ST_COLLECT;
            remaining     <= ip_word_count;
            op_wr_addr    <= initial_addr;
            op_checksum   <= 32'd0;
            op_error      <= 1'b0;
            op_byte_ready <= 1'b1;
            op_core_hold  <= 1'b1;
            op_busy       <= 1'b1;
          end else if (start_bad) begin
            op_error <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (word_complete) begin
            state         <= ST_WRITE;
            op_wr_data    <= assembled_word;
            op_wr_en      <= 1'b1;
            op_byte_ready <= 1'b0;
          end
        end
        ST_WRITE: begin
          op_checksum <= op_checksum + op_wr_data;
          remaining   <= remaining - 1'b1;
          if (remaining == 11'd1) begin
            // Address is left on the last written word so it never passes last_addr-3
            state   <= ST_DONE;
            op_done <= 1'b1;
          end else begin
            state         <= ST_COLLECT;
            op_wr_addr    <= op_wr_addr + 32'd4;
            op_byte_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          state        <= ST_IDLE;
          op_core_hold <= 1'b0;
          op_busy      <= 1'b0;
        end
        default: begin
          state         <= ST_IDLE;
          op_byte_ready <= 1'b0;
          op_core_hold  <= 1'b0;
          op_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
